mux_3to1: RTL and testbench
===========================

Name:
mux_3to1

Overview:
- Parameterised 3-to-1 selector with an optional output register.
- Routes one of three data inputs to y under a 2-bit select formed from {sel1,sel0}.
- Flags the unused select code.
- Sits on datapath steering points. The single-bit, unregistered configuration matches the legacy combinational mux behaviour.

Parameters:
- WIDTH, 1, bit width of i0/i1/i2/y.
- REG_OUT, 1, 1 = y and sel_invalid registered (1-cycle latency); 0 = combinational path gated only by reset.
- INVALID_VAL, 0, value driven on y when select = 2'b11 (zero-extended/truncated to WIDTH).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- sel0, input, 1, select LSB.
- sel1, input, 1, select MSB.
- i0, input, WIDTH, data selected on code 2'b00.
- i1, input, WIDTH, data selected on code 2'b01.
- i2, input, WIDTH, data selected on code 2'b10.
- y, output, WIDTH, selected data.
- sel_invalid, output, 1, high when select code is 2'b11.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Select code: s = {sel1,sel0}.
  - 00 -> i0
  - 01 -> i1
  - 10 -> i2
  - 11 -> INVALID_VAL, with sel_invalid=1.
- Next-value function nxt_y/nxt_inv is purely combinational. No priority logic; exactly one source is selected per code.
- X/Z on sel0 or sel1 counts as an illegal code in simulation: nxt_y = INVALID_VAL, nxt_inv = 1. Synthesis treats it as don't-care.
- REG_OUT=1:
  - y and sel_invalid update on each rising clk edge from nxt_y/nxt_inv.
  - Latency is exactly 1 cycle; there is no enable and the registers load every cycle.
  - rst_n low clears both immediately (asynchronously) to y=0 and sel_invalid=0, independent of clk.
  - Outputs hold reset values while rst_n stays low.
  - First capture occurs on the first rising edge after rst_n deasserts. Deassertion is synchronised externally.
- REG_OUT=0:
  - y = nxt_y and sel_invalid = nxt_inv combinationally with zero latency.
  - While rst_n is low, y=0 and sel_invalid=0. clk is unused.
- Reset mid-operation: outputs drop to 0 within the same delta (async). Any in-flight captured value is discarded.
- Select changes between edges (REG_OUT=1) have no effect until the next edge. There is no glitch filtering in combinational mode.
- Data inputs wider or narrower than WIDTH are not allowed. INVALID_VAL is sized to WIDTH.

Decomposition:
- Shared package mux_pkg holds:
  - localparam select codes SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_INV=2'b11
  - typedef sel_t (logic [1:0]).
- One natural sub-module: mux_3to1_core, the combinational select decode producing nxt_y/nxt_inv.
- The top wraps mux_3to1_core with the reset-gated register/bypass generate block.

Test Plan:
- Reset: rst_n=0 with i2,i1,i0=1,0,1 and s=00 -> y=0, sel_invalid=0 immediately and held for 3 clk edges. Release rst_n -> y=1 after the next edge (REG_OUT=1).
- Sweep: i2,i1,i0=1,0,1; s=00,01,10,11 on successive cycles.
  - REG_OUT=1: y=1,0,1,0 and sel_invalid=0,0,0,1, each one edge later.
  - REG_OUT=0: same values with zero latency.
- Wide data: WIDTH=8, i0=8'hA5, i1=8'h3C, i2=8'hF0, INVALID_VAL=8'hEE; s=10 -> y=8'hF0; s=11 -> y=8'hEE, sel_invalid=1.
- Async reset mid-stream: with y=8'hF0, pull rst_n low halfway between edges -> y=0 before the next edge. Hold for 2 edges -> y stays 0.
- Mid-cycle select change (REG_OUT=1): s switches 00->01->00 between two edges with i0=1, i1=0 -> y captures only the value at the edge (1), with no intermediate change.
- Random: 10 cycles of random {sel1,sel0} against a reference model -> y and sel_invalid match every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: select codes and select type shared by the 3-to-1 mux slice
package mux_pkg;
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_I0  = 2'b00;
  localparam sel_t SEL_I1  = 2'b01;
  localparam sel_t SEL_I2  = 2'b10;
  localparam sel_t SEL_INV = 2'b11;
endpackage

// File: rtl/mux_3to1_core.sv
// mux_3to1_core: combinational select decode producing next y and invalid flag
module mux_3to1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] INVALID_VAL = '0
) (
  input  sel_t             s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] nxt_y,
  output logic             nxt_inv
);
  // default arm also absorbs X/Z selects in simulation
  always_comb begin
    nxt_y = INVALID_VAL;
    nxt_inv = 1'b1;
    case (s)
      SEL_I0: begin nxt_y = i0; nxt_inv = 1'b0; end
      SEL_I1: begin nxt_y = i1; nxt_inv = 1'b0; end
      SEL_I2: begin nxt_y = i2; nxt_inv = 1'b0; end
      default: begin nxt_y = INVALID_VAL; nxt_inv = 1'b1; end
    endcase
  end
endmodule

// File: rtl/mux_3to1.sv
// mux_3to1: 3-to-1 selector with optional output register and invalid-code flag
module mux_3to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit REG_OUT = 1'b1,
  parameter logic [WIDTH-1:0] INVALID_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel0,
  input  logic             sel1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] y,
  output logic             sel_invalid
);
  logic [WIDTH-1:0] nxt_y;
  logic             nxt_inv;
  mux_3to1_core #(.WIDTH(WIDTH), .INVALID_VAL(INVALID_VAL)) u_core (
    .s(sel_t'({sel1, sel0})),
    .i0(i0),
    .i1(i1),
    .i2(i2),
    .nxt_y(nxt_y),
    .nxt_inv(nxt_inv)
  );
  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        y <= '0;
        sel_invalid <= 1'b0;
      end else begin
        y <= nxt_y;
        sel_invalid <= nxt_inv;
      end
  end else begin : g_comb
    assign y = rst_n ? nxt_y : '0;
    assign sel_invalid = rst_n & nxt_inv;
  end
endmodule

// File: tb/tb_mux_3to1.sv
// tb_mux_3to1: directed checks of registered, combinational and wide mux configurations
module tb_mux_3to1;
  logic clk = 1'b0;
  logic rst_n, sel0, sel1;
  logic i0, i1, i2;
  logic [7:0] w0, w1, w2;
  logic y_r, inv_r, y_c, inv_c, inv_w;
  logic [7:0] y_w;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mux_3to1 #(.WIDTH(1), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1),
    .i0(i0), .i1(i1), .i2(i2), .y(y_r), .sel_invalid(inv_r)
  );
  mux_3to1 #(.WIDTH(1), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1),
    .i0(i0), .i1(i1), .i2(i2), .y(y_c), .sel_invalid(inv_c)
  );
  mux_3to1 #(.WIDTH(8), .REG_OUT(1'b1), .INVALID_VAL(8'hEE)) dut_w (
    .clk(clk), .rst_n(rst_n), .sel0(sel0), .sel1(sel1),
    .i0(w0), .i1(w1), .i2(w2), .y(y_w), .sel_invalid(inv_w)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic ref_y(input logic [1:0] s);
    return s == 2'b00 ? 1'b1 : s == 2'b01 ? 1'b0 : s == 2'b10 ? 1'b1 : 1'b0;
  endfunction
  function automatic logic [7:0] ref_w(input logic [1:0] s);
    return s == 2'b00 ? 8'hA5 : s == 2'b01 ? 8'h3C : s == 2'b10 ? 8'hF0 : 8'hEE;
  endfunction
  logic [1:0] sweep_s [10] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
  initial begin
    rst_n = 1'b0;
    {sel1, sel0} = 2'b00;
    {i2, i1, i0} = 3'b101;
    w0 = 8'hA5; w1 = 8'h3C; w2 = 8'hF0;
    #1;
    check("rst_y_r", {7'd0, y_r}, 8'd0);
    check("rst_inv_r", {7'd0, inv_r}, 8'd0);
    check("rst_y_c", {7'd0, y_c}, 8'd0);
    check("rst_y_w", y_w, 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_y_r", {7'd0, y_r}, 8'd0);
      check("rst_hold_inv_c", {7'd0, inv_c}, 8'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_y_c", {7'd0, y_c}, 8'd1);
    check("rel_y_r_before_edge", {7'd0, y_r}, 8'd0);
    @(posedge clk); #1;
    check("rel_y_r", {7'd0, y_r}, 8'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) {sel1, sel0} = 2'(k);
      #1;
      check("sweep_y_c", {7'd0, y_c}, {7'd0, ref_y(2'(k))});
      check("sweep_inv_c", {7'd0, inv_c}, {7'd0, k == 3});
      @(posedge clk); #1;
      check("sweep_y_r", {7'd0, y_r}, {7'd0, ref_y(2'(k))});
      check("sweep_inv_r", {7'd0, inv_r}, {7'd0, k == 3});
    end
    @(negedge clk) {sel1, sel0} = 2'b10;
    @(posedge clk); #1;
    check("wide_i2", y_w, 8'hF0);
    @(negedge clk) {sel1, sel0} = 2'b11;
    @(posedge clk); #1;
    check("wide_inv_y", y_w, 8'hEE);
    check("wide_inv_flag", {7'd0, inv_w}, 8'd1);
    @(negedge clk) {sel1, sel0} = 2'b10;
    @(posedge clk); #1;
    check("wide_pre_rst", y_w, 8'hF0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("async_rst_y_w", y_w, 8'd0);
    check("async_rst_inv_w", {7'd0, inv_w}, 8'd0);
    check("async_rst_y_r", {7'd0, y_r}, 8'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("async_hold_y_w", y_w, 8'd0);
    end
    @(negedge clk) begin rst_n = 1'b1; {sel1, sel0} = 2'b01; end
    @(posedge clk); #1;
    check("mid_pre_y_r", {7'd0, y_r}, 8'd0);
    @(negedge clk) {sel1, sel0} = 2'b00;
    #2 {sel1, sel0} = 2'b01;
    #1 check("mid_hold_y_r", {7'd0, y_r}, 8'd0);
    #1 {sel1, sel0} = 2'b00;
    @(posedge clk); #1;
    check("mid_capture_y_r", {7'd0, y_r}, 8'd1);
    foreach (sweep_s[k]) begin
      @(negedge clk) {sel1, sel0} = sweep_s[k];
      #1 check("tbl_y_c", {7'd0, y_c}, {7'd0, ref_y(sweep_s[k])});
      @(posedge clk); #1;
      check("tbl_y_r", {7'd0, y_r}, {7'd0, ref_y(sweep_s[k])});
      check("tbl_inv_r", {7'd0, inv_r}, {7'd0, sweep_s[k] == 2'b11});
      check("tbl_y_w", y_w, ref_w(sweep_s[k]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
